multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset, synchronous to clk, active-high.
REQ-003 SHALL have port: opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port: zero  input  1  ALU zero flag.
REQ-005 SHALL have port: mem_ready  input  1  memory completes the current read/write this cycle.
REQ-006 SHALL have ports: pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes/selects.
REQ-007 SHALL have ports: alu_src_b, alu_op, pc_src  output  2 each  encoded selects.
REQ-008 SHALL have ports: done  output  1  one-cycle pulse on an instruction's last cycle; illegal  output  1  trap indicator; state  output  4  current state, for debug.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12. Only pc_write, ir_write and done may also depend on mem_ready/zero.
REQ-010 SHALL use these encodings: alu_src_b 00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2. alu_op 00=add, 01=sub, 10=funct. pc_src 00=ALU result, 01=ALUOut, 10=jump target. alu_src_a 0=PC, 1=A.
REQ-011 Any output not listed for a state SHALL be 0.
REQ-012 FETCH: mem_read=1, alu_src_b=01. ir_write=pc_write=mem_ready. Hold in FETCH while mem_ready=0, else go to DECODE.
REQ-013 DECODE: alu_src_b=11 (precompute branch target). Next state: 000000->R_EXEC, 001000->I_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, any other->TRAP.
REQ-014 MEM_ADDR: alu_src_a=1, alu_src_b=10. Go to MEM_RD if opcode=100011, else MEM_WR.
REQ-015 MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
REQ-016 MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH. done=mem_ready.
REQ-017 MEM_WB: reg_write=1, mem_to_reg=1, done=1, then go to FETCH.
REQ-018 R_EXEC: alu_src_a=1, alu_op=10, then go to R_WB. R_WB: reg_write=1, reg_dst=1, done=1, then go to FETCH.
REQ-019 I_EXEC: alu_src_a=1, alu_src_b=10, then go to I_WB. I_WB: reg_write=1, done=1, then go to FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_write=zero, done=1, then go to FETCH.
REQ-021 JUMP: pc_src=10, pc_write=1, done=1, then go to FETCH.
REQ-022 TRAP: illegal=1 and all writes 0. TRAP SHALL persist until rst.
REQ-023 Zero-wait-state latency, counted from FETCH entry to done: add/addi 4, lw 5, sw 4, beq 3, j 3 cycles. Each mem_ready=0 cycle adds one cycle.
REQ-024 opcode SHALL be sampled only in DECODE and MEM_ADDR. Changes in opcode during other states SHALL have no effect.

Reset
REQ-025 While rst=1 at a clk edge, the state SHALL become FETCH. During any cycle with rst=1, every write/strobe output (pc_write, ir_write, mem_read, mem_write, reg_write, done) SHALL be forced to 0.
REQ-026 Reset asserted mid-instruction (including wait states and TRAP) SHALL abandon the instruction. No partial writes SHALL occur after the asserting edge.

Structure
REQ-027 A shared package SHALL hold the state enum, opcode constants, and the alu_op/alu_src_b/pc_src encodings, for reuse by the datapath and the bench.
REQ-028 The state register and next-state logic SHALL form the top. One combinational sub-module, mc_ctrl_out, SHALL map {state, mem_ready, zero} to the control outputs.

Verification
REQ-029 add (000000), mem_ready=1 -> states 0,1,6,7. In state 7: reg_write=1, reg_dst=1, done=1. Back to 0 on cycle 5.
REQ-030 lw (100011), mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_read=i_or_d=1 throughout. Then MEM_WB: mem_to_reg=1, reg_write=1.
REQ-031 beq (000100) with zero=1 -> BRANCH: pc_write=1, pc_src=01. With zero=0 -> pc_write=0, done=1. Both cases: FETCH next.
REQ-032 Opcode 111111 -> TRAP, illegal=1. Remains in TRAP for 20 cycles with no writes. rst=1 -> FETCH, illegal=0.
REQ-033 rst=1 during MEM_WR with mem_ready=1 -> mem_write=0 that cycle. Next state FETCH.
REQ-034 FETCH with mem_ready=0 for 3 cycles -> ir_write=pc_write=0, state 0 held. On mem_ready=1 -> one-cycle ir_write=pc_write=1, then DECODE.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcodes and
// the datapath select encodings used by both the controller and the datapath.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11,
        StTrap    = 4'd12
    } state_e;

    // Instruction opcodes, bits [31:26]
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    // ALU operand B select
    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    // ALU operation
    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    // Next-PC source
    localparam logic [1:0] PcAluRes = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    // ALU operand A select
    localparam logic SrcAPc  = 1'b0;
    localparam logic SrcAReg = 1'b1;

    // First state after DECODE for a given opcode; unknown opcodes trap.
    function automatic state_e decode_next(input logic [5:0] op);
        state_e st;
        case (op)
            OpRType:    st = StRExec;
            OpAddi:     st = StIExec;
            OpLw, OpSw: st = StMemAddr;
            OpBeq:      st = StBranch;
            OpJ:        st = StJump;
            default:    st = StTrap;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mc_ctrl_out.sv
// Moore output decoder: maps the current state (plus mem_ready/zero for the few
// strobes allowed to depend on them) to the datapath control signals.
module mc_ctrl_out
    import multicycle_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       done_o,
    output logic       illegal_o
);

    // Per-state control decode; everything not named for a state stays 0
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = SrcAPc;
        alu_src_b_o  = SrcBReg;
        alu_op_o     = AluAdd;
        pc_src_o     = PcAluRes;
        done_o       = 1'b0;
        illegal_o    = 1'b0;
        case (state_i)
            StFetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SrcBFour;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            StDecode: begin
                // Branch target precomputed while the opcode is decoded
                alu_src_b_o = SrcBImmSh2;
            end
            StMemAddr, StIExec: begin
                alu_src_a_o = SrcAReg;
                alu_src_b_o = SrcBImm;
            end
            StMemRd: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            StMemWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                done_o       = 1'b1;
            end
            StMemWr: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                done_o      = mem_ready_i;
            end
            StRExec: begin
                alu_src_a_o = SrcAReg;
                alu_op_o    = AluFunct;
            end
            StRWb: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                done_o      = 1'b1;
            end
            StBranch: begin
                alu_src_a_o = SrcAReg;
                alu_op_o    = AluSub;
                pc_src_o    = PcAluOut;
                pc_write_o  = zero_i;
                done_o      = 1'b1;
            end
            StJump: begin
                pc_src_o   = PcJump;
                pc_write_o = 1'b1;
                done_o     = 1'b1;
            end
            StIWb: begin
                reg_write_o = 1'b1;
                done_o      = 1'b1;
            end
            StTrap: begin
                illegal_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: state register and next-state logic, with the
// output decode delegated to mc_ctrl_out. Strobes are masked while rst is high.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       done,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q, state_d;

    logic pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw;
    logic reg_write_raw, done_raw;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode is only looked at in DECODE and MEM_ADDR
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode:  state_d = decode_next(opcode);
            StMemAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready) state_d = StMemWb;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StRExec:   state_d = StRWb;
            StIExec:   state_d = StIWb;
            StMemWb, StRWb, StBranch, StJump, StIWb: state_d = StFetch;
            StTrap:    state_d = StTrap;
            default:   state_d = StFetch;
        endcase
    end

    mc_ctrl_out u_ctrl_out (
        .state_i      (state_q),
        .mem_ready_i  (mem_ready),
        .zero_i       (zero),
        .pc_write_o   (pc_write_raw),
        .ir_write_o   (ir_write_raw),
        .i_or_d_o     (i_or_d),
        .mem_read_o   (mem_read_raw),
        .mem_write_o  (mem_write_raw),
        .reg_write_o  (reg_write_raw),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .pc_src_o     (pc_src),
        .done_o       (done_raw),
        .illegal_o    (illegal)
    );

    // Reset abandons the instruction in the same cycle: no side effects escape
    assign pc_write  = pc_write_raw  & ~rst;
    assign ir_write  = ir_write_raw  & ~rst;
    assign mem_read  = mem_read_raw  & ~rst;
    assign mem_write = mem_write_raw & ~rst;
    assign reg_write = reg_write_raw & ~rst;
    assign done      = done_raw      & ~rst;
    assign state     = state_q;

endmodule
